// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the ID/EX/MEM datapath and the hazard controller.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_load_inst;
    logic                  jump_branch_taken;
    logic                  invalid_inst;
    logic                  mem_access;
    logic                  dmem_ready;
    logic                  cnt_clr;

    logic                  if_id_pipeline_flush;
    logic                  if_id_pipeline_en;
    logic                  id_ex_pipeline_flush;
    logic                  id_ex_pipeline_en;
    logic                  ex_mem_pipeline_en;
    logic                  pc_en;
    logic                  load_stall;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, opcode, ex_rd, ex_load_inst, jump_branch_taken,
               invalid_inst, mem_access, dmem_ready, cnt_clr,
        input  if_id_pipeline_flush, if_id_pipeline_en, id_ex_pipeline_flush,
               id_ex_pipeline_en, ex_mem_pipeline_en, pc_en, load_stall,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, opcode, ex_rd, ex_load_inst, jump_branch_taken,
               invalid_inst, mem_access, dmem_ready, cnt_clr,
        output if_id_pipeline_flush, if_id_pipeline_en, id_ex_pipeline_flush,
               id_ex_pipeline_en, ex_mem_pipeline_en, pc_en, load_stall,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / memory-freeze hazard controller for a 5-stage RISC-V pipeline,
// with saturating stall and flush performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_S     = 7'b0100011;

    localparam logic [0:0] RUN       = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    localparam int              LC_W    = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
    localparam logic [LC_W-1:0] LC_INIT = LC_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  rs1_used, rs2_used, load_hazard, mem_freeze, flush_evt;
    logic [0:0]            state, state_nxt;
    logic [LC_W-1:0]       ld_cnt, ld_nxt;
    logic                  if_id_flush, if_id_en, id_ex_flush, id_ex_en, ex_mem_en;
    logic                  pc_en, load_stall;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (bus.opcode)
            OP_R, OP_S, OP_B:           begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_I_ALU, OP_LOAD, OP_JALR: rs1_used = 1'b1;
            default:                    ;
        endcase
    end

    assign load_hazard = bus.ex_load_inst && (rd != '0) &&
                         ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    assign mem_freeze  = bus.mem_access && !bus.dmem_ready;
    assign flush_evt   = !mem_freeze && bus.jump_branch_taken;

    // Strict priority: freeze > redirect > LOAD_WAIT > new load-use > illegal instruction.
    always_comb begin
        if_id_flush = 1'b0;
        if_id_en    = 1'b1;
        id_ex_flush = 1'b0;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        pc_en       = 1'b1;
        load_stall  = 1'b0;
        state_nxt   = state;
        ld_nxt      = ld_cnt;
        if (mem_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (bus.jump_branch_taken) begin
            if_id_flush = 1'b1;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
            ld_nxt      = '0;
        end else if (state == LOAD_WAIT) begin
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            pc_en       = 1'b0;
            load_stall  = 1'b1;
            if (ld_cnt == '0) state_nxt = RUN;
            else              ld_nxt    = ld_cnt - 1'b1;
        end else if (load_hazard) begin
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            pc_en       = 1'b0;
            load_stall  = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = LOAD_WAIT;
                ld_nxt    = LC_INIT;
            end
        end else if (bus.invalid_inst) begin
            id_ex_flush = 1'b1;
        end
    end

    // While reset is held the whole front end is frozen and flushed.
    assign bus.pc_en                = rst_n & pc_en;
    assign bus.if_id_pipeline_en    = rst_n & if_id_en;
    assign bus.id_ex_pipeline_en    = rst_n & id_ex_en;
    assign bus.ex_mem_pipeline_en   = rst_n & ex_mem_en;
    assign bus.if_id_pipeline_flush = !rst_n | if_id_flush;
    assign bus.id_ex_pipeline_flush = !rst_n | id_ex_flush;
    assign bus.load_stall           = rst_n & load_stall;
    assign bus.stall_cnt            = stall_cnt;
    assign bus.flush_cnt            = flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ld_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= ld_nxt;
            if (bus.cnt_clr)  stall_cnt <= '0;
            else if (!pc_en)  stall_cnt <= sat_inc(stall_cnt);
            if (bus.cnt_clr)  flush_cnt <= '0;
            else if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl (LOAD_LAT=1/CNT_W=32 and LOAD_LAT=3/CNT_W=4)
// against a remaining-bubble-count reference model.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, ex_rd;
    logic [6:0] opcode;
    logic       ex_load, jbt, invalid, mem_access, dmem_ready, cnt_clr;

    int n_chk = 0;
    int n_err = 0;

    int     rem1, rem3;
    longint sc1, fc1, sc3, fc3;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_B = 7'b1100011, OP_S = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_JAL = 7'b1101111;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus1 ();
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus3 ();

    assign bus1.id_rs1 = rs1;            assign bus3.id_rs1 = rs1;
    assign bus1.id_rs2 = rs2;            assign bus3.id_rs2 = rs2;
    assign bus1.opcode = opcode;         assign bus3.opcode = opcode;
    assign bus1.ex_rd = ex_rd;           assign bus3.ex_rd = ex_rd;
    assign bus1.ex_load_inst = ex_load;  assign bus3.ex_load_inst = ex_load;
    assign bus1.jump_branch_taken = jbt; assign bus3.jump_branch_taken = jbt;
    assign bus1.invalid_inst = invalid;  assign bus3.invalid_inst = invalid;
    assign bus1.mem_access = mem_access; assign bus3.mem_access = mem_access;
    assign bus1.dmem_ready = dmem_ready; assign bus3.dmem_ready = dmem_ready;
    assign bus1.cnt_clr = cnt_clr;       assign bus3.cnt_clr = cnt_clr;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_hazard();
        bit u1, u2;
        u1 = opcode inside {OP_R, OP_I, OP_LD, OP_JALR, OP_B, OP_S};
        u2 = opcode inside {OP_R, OP_S, OP_B};
        return ex_load && (ex_rd != 0) && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
    endfunction

    // {if_id_flush, if_id_en, id_ex_flush, id_ex_en, ex_mem_en, pc_en, load_stall}
    function automatic logic [6:0] ref_ctrl(input int rem);
        if (!rst_n)                      return 7'b1010000;
        if (mem_access && !dmem_ready)   return 7'b0000000;
        if (jbt)                         return 7'b1011110;
        if (rem > 0 || ref_hazard())     return 7'b0011101;
        if (invalid)                     return 7'b0111110;
        return 7'b0101110;
    endfunction

    task automatic model_step(inout int rem, inout longint sc, inout longint fc,
                              input int lat, input longint cmax);
        logic [6:0] c;
        bit frz;
        c   = ref_ctrl(rem);
        frz = mem_access && !dmem_ready;
        if (cnt_clr) sc = 0;
        else if (!c[1] && sc < cmax) sc++;
        if (cnt_clr) fc = 0;
        else if (!frz && jbt && fc < cmax) fc++;
        if (frz)               rem = rem;
        else if (jbt)          rem = 0;
        else if (rem > 0)      rem--;
        else if (ref_hazard()) rem = lat - 1;
    endtask

    function automatic logic [6:0] ctrl1();
        return {bus1.if_id_pipeline_flush, bus1.if_id_pipeline_en, bus1.id_ex_pipeline_flush,
                bus1.id_ex_pipeline_en, bus1.ex_mem_pipeline_en, bus1.pc_en, bus1.load_stall};
    endfunction
    function automatic logic [6:0] ctrl3();
        return {bus3.if_id_pipeline_flush, bus3.if_id_pipeline_en, bus3.id_ex_pipeline_flush,
                bus3.id_ex_pipeline_en, bus3.ex_mem_pipeline_en, bus3.pc_en, bus3.load_stall};
    endfunction

    // Called right after a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        #1;
        chk("ctrl_lat1", 64'(ctrl1()), 64'(ref_ctrl(rem1)));
        chk("ctrl_lat3", 64'(ctrl3()), 64'(ref_ctrl(rem3)));
        @(posedge clk);
        if (rst_n) begin
            model_step(rem1, sc1, fc1, 1, 64'hFFFF_FFFF);
            model_step(rem3, sc3, fc3, 3, 64'd15);
        end
        #1;
        chk("stall_cnt_lat1", 64'(bus1.stall_cnt), 64'(sc1));
        chk("flush_cnt_lat1", 64'(bus1.flush_cnt), 64'(fc1));
        chk("stall_cnt_lat3", 64'(bus3.stall_cnt), 64'(sc3));
        chk("flush_cnt_lat3", 64'(bus3.flush_cnt), 64'(fc3));
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 5'd1; rs2 = 5'd2; ex_rd = 5'd0; opcode = OP_R;
        ex_load = 0; jbt = 0; invalid = 0; mem_access = 0; dmem_ready = 1; cnt_clr = 0;
    endtask

    task automatic set_hazard();
        idle();
        ex_load = 1; ex_rd = 5'd5; opcode = OP_R; rs1 = 5'd1; rs2 = 5'd5;
    endtask

    // Starts at a negedge; asserts reset mid-phase, checks, releases on the next negedge.
    task automatic do_reset();
        #3;
        rst_n = 0;
        #1;
        chk("rst_stall_cnt_lat1", 64'(bus1.stall_cnt), 64'd0);
        chk("rst_stall_cnt_lat3", 64'(bus3.stall_cnt), 64'd0);
        chk("rst_flush_cnt_lat3", 64'(bus3.flush_cnt), 64'd0);
        chk("rst_ctrl_lat1", 64'(ctrl1()), 64'(7'b1010000));
        chk("rst_ctrl_lat3", 64'(ctrl3()), 64'(7'b1010000));
        rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
        @(negedge clk);
        do_reset();

        // Single load-use hazard: 1 bubble for LOAD_LAT=1, 3 for LOAD_LAT=3
        set_hazard();
        #1;
        chk("lat1_hazard_ctrl", 64'(ctrl1()), 64'(7'b0011101));
        tick();
        idle();
        repeat (3) tick();
        chk("lat1_stall_total", 64'(bus1.stall_cnt), 64'd1);
        chk("lat3_stall_total", 64'(bus3.stall_cnt), 64'd3);
        chk("lat3_pc_en_after", 64'(bus3.pc_en), 64'd1);

        // No hazard: destination x0, and LUI reading no registers
        set_hazard(); ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        set_hazard(); opcode = OP_LUI; rs1 = 5'd5;
        tick();
        chk("no_stall_lat3", 64'(bus3.stall_cnt), 64'd3);

        // Hazard then 2 freeze cycles inside LOAD_WAIT
        idle(); cnt_clr = 1; tick();
        set_hazard(); tick();
        idle(); mem_access = 1; dmem_ready = 0;
        #1;
        chk("freeze_ctrl_lat3", 64'(ctrl3()), 64'(7'b0000000));
        tick(); tick();
        idle();
        repeat (3) tick();
        chk("freeze_stall_lat3", 64'(bus3.stall_cnt), 64'd5);
        chk("freeze_stall_lat1", 64'(bus1.stall_cnt), 64'd3);

        // Redirect wins over a simultaneous load-use hazard
        idle(); cnt_clr = 1; tick();
        set_hazard(); jbt = 1;
        #1;
        chk("redirect_ctrl_lat3", 64'({bus3.if_id_pipeline_flush, bus3.id_ex_pipeline_flush,
                                        bus3.pc_en, bus3.load_stall}), 64'(4'b1110));
        tick();
        idle(); tick();
        chk("redirect_flush_cnt", 64'(bus3.flush_cnt), 64'd1);

        // Saturation of the 4-bit counter, then clear-over-increment
        idle(); cnt_clr = 1; tick();
        idle(); mem_access = 1; dmem_ready = 0;
        repeat (20) tick();
        chk("sat_stall_lat3", 64'(bus3.stall_cnt), 64'd15);
        chk("nosat_stall_lat1", 64'(bus1.stall_cnt), 64'd20);
        cnt_clr = 1; tick();
        chk("clr_over_inc_lat3", 64'(bus3.stall_cnt), 64'd0);

        // Reset during LOAD_WAIT, resume in RUN
        set_hazard(); tick();
        idle(); tick();
        do_reset();
        idle();
        #1;
        chk("post_rst_pc_en_lat3", 64'(bus3.pc_en), 64'd1);
        chk("post_rst_pc_en_lat1", 64'(bus1.pc_en), 64'd1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ops [8];
            ops = '{OP_R, OP_I, OP_LD, OP_JALR, OP_B, OP_S, OP_LUI, OP_JAL};
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            opcode     = ops[$urandom_range(0, 7)];
            ex_load    = ($urandom_range(0, 2) == 0);
            jbt        = ($urandom_range(0, 9) == 0);
            invalid    = ($urandom_range(0, 7) == 0);
            mem_access = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 1) == 0);
            cnt_clr    = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
